// File: rtl/disparity_frame_buffer.sv
// Frame store behind the stereo disparity stage: captures HSYNC-strobed pixel pairs
// in raster order, then drains the finished frame as a 1-pixel-per-beat valid/ready stream.
module disparity_frame_buffer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       vsync_in,
    input  logic       hsync_in,
    input  logic [7:0] data0_in,
    input  logic [7:0] data1_in,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [7:0] pix_data,
    output logic       pix_last,
    output logic       frame_done,
    output logic       busy,
    output logic       overflow_err,
    output logic [8:0] wr_row,
    output logic [8:0] wr_col
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int NPAIR = NPIX / 2;
    localparam int PW    = $clog2(NPAIR);
    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NPIX - 2);
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NPIX - 1);
    localparam logic [8:0]        COL_WRAP  = 9'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_next;
    logic              wr_en;
    logic              rd_en;
    logic              handshake;
    logic              rd_sel;
    logic [7:0]        rd_even;
    logic [7:0]        rd_odd;

    // Even pixels live in one bank and odd pixels in the other, so a pair lands in one cycle.
    logic [7:0] mem_even [NPAIR];
    logic [7:0] mem_odd  [NPAIR];

    assign wr_en     = (state == FILL) && hsync_in && !vsync_in;
    assign handshake = pix_valid && pix_ready;
    // First DRAIN cycle fetches pixel 0; afterwards each non-final handshake pre-fetches the next one.
    assign rd_en     = (state == DRAIN) && (!pix_valid || (handshake && !pix_last));
    assign rd_next   = pix_valid ? rd_addr + ADDR_W'(1) : rd_addr;

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            mem_even[wr_addr[PW:1]] <= data0_in;
            mem_odd[wr_addr[PW:1]]  <= data1_in;
        end
        if (rd_en) begin
            rd_even <= mem_even[rd_next[PW:1]];
            rd_odd  <= mem_odd[rd_next[PW:1]];
        end
    end

    assign pix_data = pix_valid ? (rd_sel ? rd_odd : rd_even) : 8'd0;
    assign busy     = (state == FILL) || (state == DRAIN);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= IDLE;
            wr_addr      <= '0;
            rd_addr      <= '0;
            wr_row       <= '0;
            wr_col       <= '0;
            rd_sel       <= 1'b0;
            pix_valid    <= 1'b0;
            pix_last     <= 1'b0;
            frame_done   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hsync_in) overflow_err <= 1'b1;
                    if (vsync_in) begin
                        state   <= FILL;
                        wr_addr <= '0;
                        wr_row  <= '0;
                        wr_col  <= '0;
                    end
                end
                FILL: begin
                    // A VSYNC level restarts the capture and swallows any coincident pair.
                    if (vsync_in) begin
                        wr_addr <= '0;
                        wr_row  <= '0;
                        wr_col  <= '0;
                    end else if (hsync_in) begin
                        if (wr_addr == LAST_PAIR) begin
                            wr_addr <= '0;
                            rd_addr <= '0;
                            state   <= DRAIN;
                        end else begin
                            wr_addr <= wr_addr + ADDR_W'(2);
                        end
                        if (wr_col == COL_WRAP) begin
                            wr_col <= '0;
                            wr_row <= wr_row + 9'd1;
                        end else begin
                            wr_col <= wr_col + 9'd2;
                        end
                    end
                end
                DRAIN: begin
                    if (hsync_in) overflow_err <= 1'b1;
                    if (rd_en) begin
                        rd_addr   <= rd_next;
                        rd_sel    <= rd_next[0];
                        pix_valid <= 1'b1;
                        pix_last  <= (rd_next == LAST_PIX);
                    end else if (handshake && pix_last) begin
                        pix_valid  <= 1'b0;
                        pix_last   <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (hsync_in) overflow_err <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disparity_frame_buffer.sv
// Randomized self-checking bench for disparity_frame_buffer on a small 8x2 frame;
// expected pixels come from a queue model of what a frame capture should hold.
module tb_disparity_frame_buffer;

    localparam int W = 8;
    localparam int H = 2;
    localparam int N = W * H;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       vsync_in = 1'b0;
    logic       hsync_in = 1'b0;
    logic [7:0] data0_in = 8'd0;
    logic [7:0] data1_in = 8'd0;
    logic       pix_ready = 1'b0;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_last;
    logic       frame_done;
    logic       busy;
    logic       overflow_err;
    logic [8:0] wr_row;
    logic [8:0] wr_col;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    disparity_frame_buffer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .vsync_in(vsync_in), .hsync_in(hsync_in),
        .data0_in(data0_in), .data1_in(data1_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
        .frame_done(frame_done), .busy(busy), .overflow_err(overflow_err),
        .wr_row(wr_row), .wr_col(wr_col)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic start_frame(input int len);
        vsync_in = 1'b1;
        repeat (len) begin @(posedge HCLK); #1; end
        vsync_in = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_pair(input logic [7:0] d0, input logic [7:0] d1);
        hsync_in = 1'b1; data0_in = d0; data1_in = d1;
        @(posedge HCLK); #1;
        hsync_in = 1'b0;
        exp_q.push_back(d0);
        exp_q.push_back(d1);
    endtask

    task automatic send_random_frame(input bit gaps);
        for (int k = 0; k < N / 2; k++) begin
            send_pair(8'($urandom), 8'($urandom));
            if (gaps && k != N / 2 - 1)
                repeat ($urandom_range(0, 2)) begin @(posedge HCLK); #1; end
        end
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,..., 2: random ready
    task automatic drain_check(input string tag, input int mode, input bit inject);
        int idx = 0;
        int cyc = 0;
        int first = -1;
        bit prev_stall = 1'b0;
        bit finished = 1'b0;
        logic [7:0] pd = 8'd0;
        logic pl = 1'b0;
        while (!finished && cyc < 400) begin
            case (mode)
                0: pix_ready = 1'b1;
                1: pix_ready = (cyc % 3 == 0);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (inject && cyc == 3) begin
                hsync_in = 1'b1; data0_in = 8'hEE; data1_in = 8'hEF;
            end
            if (inject && cyc == 4) hsync_in = 1'b0;
            @(negedge HCLK);
            if (pix_valid && prev_stall) begin
                checks++;
                if (pix_data !== pd || pix_last !== pl) begin
                    errors++;
                    $display("FAIL %s stall_hold: data=%h last=%b, required data=%h last=%b",
                             tag, pix_data, pix_last, pd, pl);
                end
            end
            prev_stall = pix_valid && !pix_ready;
            pd = pix_data;
            pl = pix_last;
            if (pix_valid && pix_ready) begin
                if (first < 0) first = cyc;
                checks++;
                if (idx >= N || pix_data !== exp_q[idx]) begin
                    errors++;
                    $display("FAIL %s pix_data[%0d]: got %h, required %h", tag, idx, pix_data,
                             (idx < N) ? exp_q[idx] : 8'h00);
                end
                checks++;
                if (pix_last !== (idx == N - 1)) begin
                    errors++;
                    $display("FAIL %s pix_last[%0d]: got %b, required %b", tag, idx, pix_last,
                             (idx == N - 1));
                end
                if (pix_last === 1'b1 || idx >= N - 1) finished = 1'b1;
                idx++;
            end
            @(posedge HCLK); #1;
            cyc++;
        end
        pix_ready = 1'b0;
        hsync_in = 1'b0;
        checks++;
        if (!finished || idx != N) begin
            errors++;
            $display("FAIL %s handshakes: got %0d, required %0d", tag, idx, N);
        end
        if (mode == 0) begin
            checks++;
            if (cyc - first != N) begin
                errors++;
                $display("FAIL %s throughput: %0d cycles for %0d pixels", tag, cyc - first, N);
            end
        end
        if (finished) begin
            @(negedge HCLK);
            checks++;
            if (frame_done !== 1'b1 || pix_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s done_pulse: frame_done=%b pix_valid=%b, required 1 0",
                         tag, frame_done, pix_valid);
            end
            @(posedge HCLK); #1;
            @(negedge HCLK);
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s after_done: frame_done=%b busy=%b, required 0 0",
                         tag, frame_done, busy);
            end
            @(posedge HCLK); #1;
        end
    endtask

    task automatic test_reset();
        logic [30:0] obs;
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        obs = {pix_valid, pix_last, frame_done, busy, overflow_err, pix_data, wr_row, wr_col};
        checks++;
        if (obs !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", obs);
        end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
    endtask

    task automatic test_basic();
        start_frame(1);
        for (int k = 0; k < N / 2; k++) send_pair(8'(2 * k), 8'(2 * k + 1));
        @(negedge HCLK);
        checks++;
        if (busy !== 1'b1 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic drain_entry: busy=%b pix_valid=%b, required 1 0", busy, pix_valid);
        end
        @(posedge HCLK); #1;
        drain_check("basic", 0, 1'b0);
    endtask

    task automatic test_stall();
        start_frame(2);
        send_random_frame(1'b0);
        drain_check("stall", 1, 1'b0);
    endtask

    task automatic test_rowcol();
        start_frame(1);
        for (int k = 0; k < 3; k++) send_pair(8'($urandom), 8'($urandom));
        @(negedge HCLK);
        checks++;
        if (wr_col !== 9'd6 || wr_row !== 9'd0) begin
            errors++;
            $display("FAIL rowcol_3: col=%0d row=%0d, required 6 0", wr_col, wr_row);
        end
        @(posedge HCLK); #1;
        send_pair(8'($urandom), 8'($urandom));
        @(negedge HCLK);
        checks++;
        if (wr_col !== 9'd0 || wr_row !== 9'd1) begin
            errors++;
            $display("FAIL rowcol_4: col=%0d row=%0d, required 0 1", wr_col, wr_row);
        end
        @(posedge HCLK); #1;
        for (int k = 4; k < N / 2; k++) send_pair(8'($urandom), 8'($urandom));
        drain_check("rowcol", 2, 1'b0);
    endtask

    task automatic test_restart();
        start_frame(1);
        for (int k = 0; k < 3; k++) send_pair(8'($urandom), 8'($urandom));
        vsync_in = 1'b1; hsync_in = 1'b1; data0_in = 8'hAA; data1_in = 8'hAA;
        @(posedge HCLK); #1;
        vsync_in = 1'b0; hsync_in = 1'b0;
        exp_q.delete();
        for (int k = 0; k < N / 2; k++) send_pair(8'(8'h10 + 2 * k), 8'(8'h11 + 2 * k));
        drain_check("restart", 0, 1'b0);
        checks++;
        if (overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL restart overflow_err: got %b, required 0", overflow_err);
        end
    endtask

    task automatic test_overflow();
        hsync_in = 1'b1; data0_in = 8'h55; data1_in = 8'h66;
        @(posedge HCLK); #1;
        hsync_in = 1'b0;
        @(negedge HCLK);
        checks++;
        if (overflow_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hsync: overflow_err=%b busy=%b, required 1 0", overflow_err, busy);
        end
        @(posedge HCLK); #1;
        start_frame(1);
        send_random_frame(1'b1);
        drain_check("after_ovf", 2, 1'b0);
        checks++;
        if (overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b, required 1", overflow_err);
        end
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        start_frame(1);
        send_random_frame(1'b0);
        drain_check("drain_hsync", 0, 1'b1);
        checks++;
        if (overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL drain_hsync overflow_err: got %b, required 1", overflow_err);
        end
    endtask

    task automatic test_reset_mid_drain();
        int hs = 0;
        int cyc = 0;
        int fd = 0;
        start_frame(1);
        send_random_frame(1'b0);
        pix_ready = 1'b1;
        while (hs < 5 && cyc < 50) begin
            @(negedge HCLK);
            if (pix_valid && pix_ready) begin
                checks++;
                if (pix_data !== exp_q[hs]) begin
                    errors++;
                    $display("FAIL middrain pix_data[%0d]: got %h, required %h", hs, pix_data, exp_q[hs]);
                end
                hs++;
            end
            @(posedge HCLK); #1;
            cyc++;
        end
        #2;
        HRESETn = 1'b0;
        #1;
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL middrain_reset: valid=%b busy=%b done=%b ovf=%b, required 0 0 0 0",
                     pix_valid, busy, frame_done, overflow_err);
        end
        pix_ready = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        repeat (10) begin
            @(negedge HCLK);
            if (frame_done) fd++;
        end
        checks++;
        if (fd != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL middrain_no_done: pulses=%0d busy=%b, required 0 0", fd, busy);
        end
        @(posedge HCLK); #1;
        start_frame(1);
        send_random_frame(1'b0);
        drain_check("after_reset", 0, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            start_frame($urandom_range(1, 4));
            for (int k = 0; k < 2; k++) send_pair(8'($urandom), 8'($urandom));
            vsync_in = 1'b1;
            for (int c = 0; c < 3; c++) begin
                hsync_in = 1'($urandom_range(0, 1));
                data0_in = 8'($urandom); data1_in = 8'($urandom);
                @(posedge HCLK); #1;
            end
            vsync_in = 1'b0; hsync_in = 1'b0;
            exp_q.delete();
            @(negedge HCLK);
            checks++;
            if (wr_row !== 9'd0 || wr_col !== 9'd0 || overflow_err !== 1'b0) begin
                errors++;
                $display("FAIL vsync_hold: row=%0d col=%0d ovf=%b, required 0 0 0",
                         wr_row, wr_col, overflow_err);
            end
            @(posedge HCLK); #1;
            send_random_frame(1'b1);
            drain_check("random", 2, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_rowcol();
        test_restart();
        test_overflow();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disparity_frame_buffer.md
Name: disparity_frame_buffer

Overview:
- Downstream consumer of the stereo disparity stage.
- Captures the disparity pixel pairs the stage emits on each HSYNC strobe, in raster order, into an internal WIDTH*HEIGHT byte frame store.
- Once the frame is complete, drains it as a 1-pixel-per-beat valid/ready stream for the image writer or display path.
- Flags protocol errors: data arriving when no frame is being captured.

Parameters:
WIDTH, 320, image width in pixels; must be even
HEIGHT, 240, image height in lines
ADDR_W, 17, frame-store address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
HCLK  input  1  clock, all logic on rising edge
HRESETn  input  1  reset; asynchronous, active-low
vsync_in  input  1  level-high frame-start indication from the disparity stage
hsync_in  input  1  one-cycle strobe; data0_in/data1_in valid this cycle
data0_in  input  8  disparity of even pixel (col)
data1_in  input  8  disparity of odd pixel (col+1)
pix_valid  output  1  output stream valid
pix_ready  input  1  output stream ready from consumer
pix_data  output  8  output pixel, raster order
pix_last  output  1  high with the final pixel of the frame (index WIDTH*HEIGHT-1)
frame_done  output  1  one-cycle pulse after the last pixel handshake
busy  output  1  high in FILL or DRAIN
overflow_err  output  1  sticky error flag; cleared only by reset
wr_row  output  9  current capture row
wr_col  output  9  current capture column (always even)

Behaviour:
- Reset (asynchronous, HRESETn low), effective immediately regardless of state:
  - state=IDLE; all outputs 0; wr/rd addresses 0.
  - Frame-store contents are not reset.
  - Reset mid-FILL or mid-DRAIN aborts the frame, with no frame_done.
- FSM states: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - vsync_in=1 -> FILL; wr_addr, wr_row and wr_col cleared.
  - hsync_in=1 -> overflow_err<=1; data dropped.
- FILL:
  - On hsync_in=1, in the same cycle: mem[wr_addr]<=data0_in, mem[wr_addr+1]<=data1_in, wr_addr+=2.
  - wr_col+=2; when wr_col==WIDTH-2 it wraps to 0 and wr_row+=1.
  - When the write at wr_addr==WIDTH*HEIGHT-2 occurs -> DRAIN next cycle; rd_addr=0.
  - vsync_in=1 while wr_addr!=0 restarts the capture: counters cleared, state stays FILL.
  - vsync_in=1 and hsync_in=1 in the same cycle: vsync wins, the pair is dropped, counters are cleared, and overflow_err is not set.
  - vsync_in held high across many cycles keeps the counters at 0. The upstream VSYNC is a multi-cycle level, so this is normal.
- DRAIN:
  - The memory read is registered, so the first pix_valid rises 1 cycle after entering DRAIN.
  - While pix_valid=1 and pix_ready=0, pix_data and pix_last hold stable and pix_valid stays high.
  - Each handshake (pix_valid & pix_ready) advances rd_addr.
  - With pix_ready held high, the next pixel is presented on the very next cycle, giving 1 pixel/cycle throughput. The read is pre-issued for rd_addr+1.
  - pix_last=1 exactly when the presented pixel index is WIDTH*HEIGHT-1.
  - Handshake on pix_last -> DONE; pix_valid drops next cycle.
  - hsync_in=1 in DRAIN -> overflow_err<=1; data dropped. vsync_in is ignored.
- DONE:
  - frame_done=1 for exactly one cycle, then IDLE.
  - hsync_in in DONE sets overflow_err.
- busy = (state==FILL || state==DRAIN).
- Arithmetic:
  - All addresses are unsigned ADDR_W bits; wr_row and wr_col are unsigned 9 bits.
  - No address ever exceeds WIDTH*HEIGHT-1.
- The frame store is inferred single-clock RAM. Pair writes use two byte lanes or two banks (even/odd), so one pair is written per cycle.
- Throughput: back-to-back hsync_in strobes (every cycle) are accepted with no loss.

Test Plan:
1. WIDTH=8, HEIGHT=2, pix_ready=1. Pulse vsync_in, then 8 hsync pairs with data0=2k, data1=2k+1 (k=0..7). -> Stream 0,1,...,15 on consecutive cycles; pix_last with 15; frame_done pulse 1 cycle after; busy low after.
2. Same frame, pix_ready toggling 1,0,0,1,... -> no pixel lost or duplicated; pix_data and pix_last stable while stalled; exactly 16 handshakes.
3. Row/col tracking, WIDTH=8: after 3 hsync -> wr_col=6, wr_row=0; after 4 -> wr_col=0, wr_row=1.
4. Mid-FILL restart: 3 pairs, then vsync_in=1 coinciding with hsync_in (data 0xAA), then 8 fresh pairs 0x10..0x1F -> output is 0x10..0x1F only; overflow_err=0.
5. Overflow: hsync_in in IDLE before any vsync -> overflow_err=1, stays 1 through a following good frame. Separately, hsync_in during DRAIN -> overflow_err=1; drained data is unchanged.
6. Reset mid-DRAIN after 5 handshakes -> pix_valid=0, frame_done never pulses, state IDLE; a new frame then streams correctly from index 0.
